// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control: load-use stall, redirect flush and registered ForwardA/B codes.
// Optional HAZARD_STATS_EN macro adds saturating stall_count/flush_count outputs.
module hazard_forward_unit #(
  parameter int               REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_next;
  logic [REG_W-1:0] ex_dest, mem_dest;
  logic             ex_reg_write, ex_mem_read, mem_reg_write;
  logic             rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic             load_use, stall;
  logic [1:0]       fwd_a_next, fwd_b_next;

  // The WB slot needs no shadow: codes are registered, so next-WB is the current MEM entry.
  assign rs_hit_ex  = id_uses_rs & ex_reg_write & (ex_dest != ZERO_REG) & (id_rs == ex_dest);
  assign rt_hit_ex  = id_uses_rt & ex_reg_write & (ex_dest != ZERO_REG) & (id_rt == ex_dest);
  assign rs_hit_mem = id_uses_rs & mem_reg_write & (mem_dest != ZERO_REG) & (id_rs == mem_dest);
  assign rt_hit_mem = id_uses_rt & mem_reg_write & (mem_dest != ZERO_REG) & (id_rt == mem_dest);
  assign load_use   = ex_mem_read & (rs_hit_ex | rt_hit_ex);

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    stall_sel  = 1'b1;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    case (state)
      RUN: begin
        if (load_use) begin
          stall      = 1'b1;
          state_next = STALL;
        end
      end
      STALL:   state_next = RUN;
      default: state_next = RUN;
    endcase
    if (stall) begin
      stall_sel  = 1'b0;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      ifid_flush = id_redirect & ~reset;
    end
  end

  // A bubble entering EX gets code 0; EX/MEM has priority over MEM/WB.
  always_comb begin
    fwd_a_next = 2'd0;
    fwd_b_next = 2'd0;
    if (!stall) begin
      if (rs_hit_ex)       fwd_a_next = 2'd1;
      else if (rs_hit_mem) fwd_a_next = 2'd2;
      if (rt_hit_ex)       fwd_b_next = 2'd1;
      else if (rt_hit_mem) fwd_b_next = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_dest      <= '0;
      mem_reg_write <= 1'b0;
      fwd_a         <= 2'd0;
      fwd_b         <= 2'd0;
    end else begin
      state         <= state_next;
      mem_dest      <= ex_dest;
      mem_reg_write <= ex_reg_write;
      ex_dest       <= id_dest;
      ex_reg_write  <= id_reg_write & ~stall;
      ex_mem_read   <= id_mem_read & ~stall;
      fwd_a         <= fwd_a_next;
      fwd_b         <= fwd_b_next;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall && stall_count != 16'hFFFF)      stall_count <= stall_count + 16'd1;
      if (ifid_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed MIPS sequences with literal expectations plus a random run
// checked against an instruction-history model (history[0]=EX, [1]=MEM, [2]=WB).
module tb_hazard_forward_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       urs;
    logic       urt;
    logic       wr;
    logic       rd;
  } ins_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_redirect;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_sel, pc_write, ifid_write, ifid_flush;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
  int          exp_stalls, exp_flushes;
`endif

  int   total = 0;
  int   bad   = 0;
  ins_t hist[3];
  ins_t cur;
  bit   cur_redir;

  hazard_forward_unit #(.REG_W(5), .ZERO_REG(5'd0)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_redirect(id_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_sel(stall_sel), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(int rs, int rt, int dest, bit urs, bit urt, bit wr, bit rd);
    ins_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.dest = 5'(dest);
    i.urs = urs; i.urt = urt; i.wr = wr; i.rd = rd;
    return i;
  endfunction

  // A load in EX whose nonzero destination is read by the ID instruction.
  function automatic bit model_stall();
    ins_t e = hist[0];
    if (!(e.rd && e.wr) || e.dest == 0) return 0;
    return (cur.urs && cur.rs == e.dest) || (cur.urt && cur.rt == e.dest);
  endfunction

  function automatic logic [1:0] model_fwd(logic [4:0] src, bit used);
    if (!used) return 2'd0;
    if (hist[1].wr && hist[1].dest != 0 && hist[1].dest == src) return 2'd1;
    if (hist[2].wr && hist[2].dest != 0 && hist[2].dest == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '0;
`ifdef HAZARD_STATS_EN
    exp_stalls = 0; exp_flushes = 0;
`endif
  endtask

  task automatic applyStimulus(ins_t i, bit redir);
    cur = i; cur_redir = redir;
    id_rs = i.rs; id_rt = i.rt; id_dest = i.dest;
    id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_reg_write = i.wr; id_mem_read = i.rd; id_redirect = redir;
  endtask

  task automatic checkOutput();
    bit s;
    @(negedge clk);
    s = model_stall();
    check("fwd_a",      fwd_a,      model_fwd(hist[0].rs, hist[0].urs));
    check("fwd_b",      fwd_b,      model_fwd(hist[0].rt, hist[0].urt));
    check("stall_sel",  stall_sel,  !s);
    check("pc_write",   pc_write,   !s);
    check("ifid_write", ifid_write, !s);
    check("ifid_flush", ifid_flush, !s && cur_redir);
`ifdef HAZARD_STATS_EN
    check("stall_count", stall_count, exp_stalls);
    check("flush_count", flush_count, exp_flushes);
`endif
  endtask

  task automatic advance();
    bit s;
    s = model_stall();
`ifdef HAZARD_STATS_EN
    if (s && exp_stalls < 65535) exp_stalls++;
    if (!s && cur_redir && exp_flushes < 65535) exp_flushes++;
`endif
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s ? ins_t'('0) : cur;
    #1;
  endtask

  task automatic cycle(ins_t i, bit redir);
    applyStimulus(i, redir);
    checkOutput();
    advance();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_fwd_a"},      fwd_a,      0);
    check({tag, "_fwd_b"},      fwd_b,      0);
    check({tag, "_stall_sel"},  stall_sel,  1);
    check({tag, "_pc_write"},   pc_write,   1);
    check({tag, "_ifid_write"}, ifid_write, 1);
    check({tag, "_ifid_flush"}, ifid_flush, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus('0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("in_reset");
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    ins_t nop, add3, lw2, use2, beq2;
    nop  = '0;
    add3 = mk(1, 2, 3, 1, 1, 1, 0);
    lw2  = mk(1, 2, 2, 1, 0, 1, 1);
    use2 = mk(2, 2, 4, 1, 1, 1, 0);
    beq2 = mk(2, 0, 0, 1, 1, 0, 0);

    do_reset();
    applyStimulus(nop, 0); checkOutput();
    check_reset_outputs("after_reset");
    advance();

    // add $3,$1,$2 ; sub $4,$3,$5
    cycle(add3, 0);
    cycle(mk(3, 5, 4, 1, 1, 1, 0), 0);
    applyStimulus(nop, 0); checkOutput();
    check("raw_exmem_fwd_a", fwd_a, 1);
    check("raw_exmem_fwd_b", fwd_b, 0);
    advance();

    // add $3 ; nop ; or $6,$5,$3
    cycle(add3, 0);
    cycle(nop, 0);
    cycle(mk(5, 3, 6, 1, 1, 1, 0), 0);
    applyStimulus(nop, 0); checkOutput();
    check("raw_memwb_fwd_a", fwd_a, 0);
    check("raw_memwb_fwd_b", fwd_b, 2);
    advance();

    // add $3 ; add $3 ; sub $4,$3,$3
    cycle(add3, 0);
    cycle(add3, 0);
    cycle(mk(3, 3, 4, 1, 1, 1, 0), 0);
    applyStimulus(nop, 0); checkOutput();
    check("prio_fwd_a", fwd_a, 1);
    check("prio_fwd_b", fwd_b, 1);
    advance();

    // lw $2,0($1) ; add $4,$2,$2
    cycle(lw2, 0);
    applyStimulus(use2, 0); checkOutput();
    check("lu_stall_sel", stall_sel, 0);
    check("lu_pc_write",  pc_write,  0);
    check("lu_ifid_write", ifid_write, 0);
    advance();
    applyStimulus(use2, 0); checkOutput();
    check("lu_once_stall_sel", stall_sel, 1);
    advance();
    applyStimulus(nop, 0); checkOutput();
    check("lu_fwd_a", fwd_a, 2);
    check("lu_fwd_b", fwd_b, 2);
    advance();

    // addi $0 ; add $5,$0,$0 and lw $0 ; add $5,$0,$0
    cycle(mk(1, 0, 0, 1, 0, 1, 0), 0);
    cycle(mk(0, 0, 5, 1, 1, 1, 0), 0);
    applyStimulus(nop, 0); checkOutput();
    check("zero_fwd_a", fwd_a, 0);
    check("zero_fwd_b", fwd_b, 0);
    advance();
    cycle(mk(1, 0, 0, 1, 0, 1, 1), 0);
    applyStimulus(mk(0, 0, 5, 1, 1, 1, 0), 0); checkOutput();
    check("zero_lw_no_stall", stall_sel, 1);
    advance();

    // Redirect held in ID while a load-use stall is in progress
    do_reset();
    cycle(lw2, 0);
    applyStimulus(beq2, 1); checkOutput();
    check("redir_stall_flush", ifid_flush, 0);
    check("redir_stall_sel",   stall_sel,  0);
    advance();
    applyStimulus(beq2, 1); checkOutput();
    check("redir_after_flush", ifid_flush, 1);
    advance();
    applyStimulus(nop, 0); checkOutput();
`ifdef HAZARD_STATS_EN
    check("stats_stall_count", stall_count, 1);
    check("stats_flush_count", flush_count, 1);
`endif
    advance();

    // Reset asserted in the middle of a stall cycle
    cycle(lw2, 0);
    applyStimulus(use2, 1); checkOutput();
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_stall_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Random instruction stream over a small register set to provoke many hazards
    for (int n = 0; n < 600; n++) begin
      ins_t r;
      r.rs   = 5'($urandom_range(0, 3));
      r.rt   = 5'($urandom_range(0, 3));
      r.dest = 5'($urandom_range(0, 3));
      r.urs  = 1'($urandom_range(0, 1));
      r.urt  = 1'($urandom_range(0, 1));
      r.wr   = ($urandom_range(0, 3) != 0);
      r.rd   = ($urandom_range(0, 2) == 0);
      cycle(r, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
